// File: rtl/hit_judge.sv
// hit_judge: per-lane note judgement with chart fetch and per-frame score/combo/accuracy latch
module hit_judge #(
    parameter int          LANES       = 4,
    parameter int          NOTE_AW     = 12,
    parameter logic [15:0] PERFECT_WIN = 16'd3,
    parameter logic [15:0] GOOD_WIN    = 16'd8,
    parameter logic [15:0] MISS_WIN    = 16'd12,
    parameter logic [12:0] PERFECT_PTS = 13'd300,
    parameter logic [12:0] GOOD_PTS    = 13'd100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               new_frame,
    input  logic [15:0]        un_time,
    input  logic [LANES-1:0]   key,
    output logic               note_rd,
    output logic [NOTE_AW-1:0] note_addr,
    input  logic [17:0]        note_q,
    output logic [12:0]        score,
    output logic [3:0]         combo,
    output logic [1:0]         precise,
    output logic               song_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAP, S_PLACE, S_END} state_t;

    localparam logic signed [16:0] GOOD_S = {1'b0, GOOD_WIN};
    localparam logic signed [16:0] MISS_S = {1'b0, MISS_WIN};

    state_t state_q, state_d;
    logic [LANES-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, edge_q, edge_d;
    logic [LANES-1:0] slot_v_q, slot_v_d;
    logic [LANES-1:0][15:0] slot_t_q, slot_t_d;
    logic [17:0] head_q, head_d;
    logic [NOTE_AW-1:0] addr_q, addr_d;
    logic nf_q, nf_d;
    logic [15:0] score_acc_q, score_acc_d;
    logic [3:0] combo_acc_q, combo_acc_d;
    logic miss_f_q, miss_f_d, perf_f_q, perf_f_d;
    logic [12:0] score_q, score_d;
    logic [3:0] combo_q, combo_d;
    logic [1:0] precise_q, precise_d;
    logic [LANES-1:0][16:0] d_w, mag_w;
    logic [LANES-1:0] perf_v, good_v, miss_v;
    logic [15:0] pts;
    logic [2:0] hits;
    logic [4:0] csum;
    logic head_end, load, frame;

    // key synchronizer chain and registered rising-edge detect
    always_comb begin
        s1_d   = key;
        s2_d   = s1_q;
        s3_d   = s2_q;
        edge_d = s2_q & ~s3_q;
    end

    // per-lane verdicts from signed timing error, summed across lanes
    always_comb begin
        perf_v = '0;
        good_v = '0;
        miss_v = '0;
        d_w    = '0;
        mag_w  = '0;
        pts    = '0;
        hits   = '0;
        for (int i = 0; i < LANES; i++) begin
            d_w[i]    = {1'b0, un_time} - {1'b0, slot_t_q[i]};
            mag_w[i]  = d_w[i][16] ? -d_w[i] : d_w[i];
            perf_v[i] = edge_q[i] & slot_v_q[i] & (mag_w[i] <= {1'b0, PERFECT_WIN});
            good_v[i] = edge_q[i] & slot_v_q[i] & ~perf_v[i] & (mag_w[i] <= {1'b0, GOOD_WIN});
            miss_v[i] = slot_v_q[i] & ($signed(d_w[i]) > GOOD_S) & (edge_q[i] | ($signed(d_w[i]) > MISS_S));
            pts       = pts + (perf_v[i] ? {3'b0, PERFECT_PTS} : good_v[i] ? {3'b0, GOOD_PTS} : 16'd0);
            hits      = hits + {2'b0, perf_v[i] | good_v[i]};
        end
    end

    // slot load from head (only into a slot empty at cycle start), clear on verdict or start
    always_comb begin
        head_end = head_q[15:0] == 16'hFFFF;
        load     = (state_q == S_PLACE) && !head_end && !slot_v_q[head_q[17:16]];
        head_d   = (state_q == S_CAP) ? note_q : head_q;
        addr_d   = start ? '0 : load ? addr_q + 1'b1 : addr_q;
        slot_v_d = slot_v_q;
        slot_t_d = slot_t_q;
        for (int i = 0; i < LANES; i++) begin
            slot_v_d[i] = start ? 1'b0 : (load && head_q[17:16] == 2'(i)) ? 1'b1 : (perf_v[i] | good_v[i] | miss_v[i]) ? 1'b0 : slot_v_q[i];
            slot_t_d[i] = (load && head_q[17:16] == 2'(i)) ? head_q[15:0] : slot_t_q[i];
        end
    end

    // frame accumulators; a frame edge latches outputs and restarts with this cycle's verdicts
    always_comb begin
        nf_d        = new_frame;
        frame       = new_frame & ~nf_q;
        csum        = {1'b0, combo_acc_q} + {2'b0, hits};
        score_acc_d = frame ? pts : score_acc_q + pts;
        combo_acc_d = frame ? {1'b0, hits} : (csum > 5'd15 ? 4'd15 : csum[3:0]);
        miss_f_d    = frame ? |miss_v : miss_f_q | (|miss_v);
        perf_f_d    = frame ? |perf_v : perf_f_q | (|perf_v);
        score_d     = frame ? (score_acc_q > 16'd8191 ? 13'h1FFF : score_acc_q[12:0]) : score_q;
        combo_d     = frame ? combo_acc_q : combo_q;
        precise_d   = frame ? {miss_f_q, perf_f_q} : precise_q;
    end

    // fetch FSM next state; start restarts from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_CAP;
            S_CAP:   state_d = S_PLACE;
            S_PLACE: state_d = head_end ? S_END : load ? S_FETCH : S_PLACE;
            default: state_d = state_q;
        endcase
        if (start) state_d = S_FETCH;
    end

    // fetch FSM outputs
    always_comb begin
        note_rd   = state_q == S_FETCH;
        note_addr = addr_q;
        song_done = (state_q == S_END) && !(|slot_v_q);
        score     = score_q;
        combo     = combo_q;
        precise   = precise_q;
    end

    // fetch FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            edge_q      <= '0;
            slot_v_q    <= '0;
            slot_t_q    <= '0;
            head_q      <= '0;
            addr_q      <= '0;
            nf_q        <= 1'b0;
            score_acc_q <= '0;
            combo_acc_q <= '0;
            miss_f_q    <= 1'b0;
            perf_f_q    <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
            precise_q   <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            edge_q      <= edge_d;
            slot_v_q    <= slot_v_d;
            slot_t_q    <= slot_t_d;
            head_q      <= head_d;
            addr_q      <= addr_d;
            nf_q        <= nf_d;
            score_acc_q <= score_acc_d;
            combo_acc_q <= combo_acc_d;
            miss_f_q    <= miss_f_d;
            perf_f_q    <= perf_f_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            precise_q   <= precise_d;
        end
    end
endmodule

// File: doc/hit_judge.md
# hit_judge

Per-lane hit-judgement stage of the rhythm-game pipeline. Streams the time-sorted note chart from note memory into one pending-note slot per lane and compares key rising edges against song time `un_time`. Produces hit or miss verdicts, then accumulates per-frame score, combo and accuracy results for the score/combo overlay renderer. That renderer sits directly downstream and samples `score`/`combo`/`precise` on the rising edge of `new_frame`.

## Interface
Parameters:
- LANES, 4, number of key lanes (note lane field is 2 bits).
- NOTE_AW, 12, note memory address width.
- PERFECT_WIN, 16'd3, max |time error| counted as perfect (un_time units).
- GOOD_WIN, 16'd8, max |time error| counted as good.
- MISS_WIN, 16'd12, lateness beyond which an unhit note times out.
- PERFECT_PTS, 13'd300, points per perfect.
- GOOD_PTS, 13'd100, points per good.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- start  in  1  one-cycle pulse: begin song, clear slots, fetch from address 0.
- new_frame  in  1  frame strobe, level, asynchronous to nothing (clk-domain signal).
- un_time  in  16  current song time, monotonic.
- key  in  LANES  raw key levels, asynchronous.
- note_rd  out  1  note memory read strobe.
- note_addr  out  NOTE_AW  note memory address.
- note_q  in  18  note word {lane[17:16], hit_time[15:0]}, valid the cycle after note_rd; hit_time 16'hFFFF = end sentinel.
- score  out  13  points earned in the previous frame.
- combo  out  4  hits (perfect+good) in the previous frame, saturating.
- precise  out  2  [1] = miss occurred in the previous frame, [0] = perfect occurred in the previous frame.
- song_done  out  1  sentinel reached and all slots empty.

## Operation
- Keys: 2-flop synchronizer per lane, then rising-edge detect.
- Slots: per lane, valid bit plus 16-bit hit_time.
- Fetch FSM:
  - Idle: wait for start.
  - Fetch: note_rd=1 with note_addr.
  - Capture: register note_q into head.
  - Place:
    - If head time is FFFF → End.
    - Else if slot[head.lane] is invalid at the start of the cycle → load slot, note_addr+1, → Fetch.
    - Else stay in Place. This preserves per-lane order; fetching stalls behind an occupied lane.
  - End: hold; song_done=1 once all slots are invalid.
  - start in any state → clear slots, note_addr=0, → Fetch.
- Judgement, per lane, every cycle, with d = {1'b0,un_time} − {1'b0,hit_time} as a 17-bit signed value:
  - Edge, slot valid, |d| ≤ PERFECT_WIN → perfect: +PERFECT_PTS, hit, perfect flag; clear slot.
  - Edge, slot valid, |d| ≤ GOOD_WIN → good: +GOOD_PTS, hit; clear slot.
  - Edge, slot valid, GOOD_WIN < d ≤ MISS_WIN → miss; clear slot.
  - Edge with d < −GOOD_WIN, or slot invalid → ignored (ghost tap).
  - No edge, slot valid, d > MISS_WIN → timeout miss; clear slot.
- Frame accumulators:
  - score_acc is 16 bits. Hit count is 3 bits per cycle; combo_acc is 4 bits, saturating at 15.
  - Flags: miss_f, perf_f.
  - All lanes' verdicts in the same cycle are summed.
- Frame boundary, on the cycle new_frame is high and was low the previous cycle:
  - score ← min(score_acc, 8191); combo ← combo_acc; precise ← {miss_f, perf_f}.
  - Accumulators reload with that cycle's verdicts only.
  - Outputs stay constant for the whole frame, so downstream sampling at the new_frame edge sees the previous frame's stable values.
- A miss and hits in the same frame are both reported: precise[1]=1 and combo=hit count. Downstream treats a set precise[1] as a combo break.

## Timing
- Reset values: all outputs 0, note_addr 0, slots invalid, accumulators 0, FSM Idle.
- Reset mid-song aborts everything; a new start is required.
- Key-to-verdict latency: 3 clk (2 synchronizer stages + edge register). The verdict updates the accumulator on the following edge.
- Fetch throughput: one note per 3 clk when lanes are free.
- A slot cleared by judgement becomes loadable on the next cycle, not the same cycle.
- start and new_frame in the same cycle: both take effect. The frame latch uses pre-start accumulators.
- un_time wrap is not supported; 16'hFFFF is reserved as the end sentinel.

## Test plan
- Note {lane 1, t=100}; key[1] rises at un_time=102 → score=300, combo=1, precise=2'b01 in the frame after the next new_frame edge; slot 1 cleared.
- Note {lane 0, t=200}, no press; un_time steps to 213 → precise=2'b10, combo=0, score=0 at the next frame latch.
- Notes on lanes 0 and 2 at t=300; both keys rise at 306 in one cycle → score=200, combo=2, precise=2'b00.
- Note {lane 3, t=500}; press at 480 → ignored, slot still valid; press at 500 → perfect.
- Chart {0,10},{0,20},{1,15},FFFF: lane-1 note is fetched only after note {0,10} is judged; song_done=1 after all three are judged.
- 16 perfects in one frame → combo=15 (saturated).
- reset asserted while in Place with a valid head → all outputs 0 next cycle; no note_rd until start.
